// File: rtl/stream_ctrl_pkg.sv
// Shared types for the stream frame sequencer: FSM states, default widths
// and the frame-geometry record.
package stream_ctrl_pkg;

  localparam int DIM_W_DEF  = 16;
  localparam int STAT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIM_W_DEF-1:0] width;
    logic [DIM_W_DEF-1:0] height;
  } geom_t;

endpackage

// File: rtl/stream_frame_ctrl_if.sv
// Ready/valid pixel stream bundle used on both sides of the frame sequencer.
interface stream_frame_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/frame_pos_counter.sv
// Column/row position tracker for a raster frame; flags the last pixel of a
// line and of the frame against the last-index bounds it is given.
module frame_pos_counter #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] w_last,
  input  logic [DIM_W-1:0] h_last,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             eol,
  output logic             eof
);

  assign eol = (col == w_last);
  assign eof = eol && (row == h_last);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (eol) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_frame_ctrl.sv
// Frame sequencer: passes exactly width*height beats from the blur output to
// the sink, tags eol/eof, signals completion and counts backpressure stalls.
module stream_frame_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  stream_frame_ctrl_if.slave  s,
  stream_frame_ctrl_if.master m,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done,
  output logic              stop_out,
  output logic              aborted,
  output logic [STAT_W-1:0] stall_cnt
);

  state_t     state;
  geom_t      geom_last;
  logic       run, xfer, start_ok, pos_eol, pos_eof;
  logic [DIM_W-1:0] col, row;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign run      = (state == RUN);
  assign start_ok = (state == IDLE) && start;
  assign xfer     = run && s.valid && m.ready;

  // Zero-latency passthrough, gated shut outside RUN
  assign m.data  = s.data;
  assign m.valid = run && s.valid;
  assign s.ready = run && m.ready;
  assign m_eol   = m.valid && pos_eol;
  assign m_eof   = m.valid && pos_eof;

  frame_pos_counter #(.DIM_W(DIM_W)) u_pos (
    .clk    (clk),
    .reset  (reset),
    .clr    (start_ok),
    .en     (xfer && !pos_eof),
    .w_last (geom_last.width),
    .h_last (geom_last.height),
    .col    (col),
    .row    (row),
    .eol    (pos_eol),
    .eof    (pos_eof)
  );

  // Last-index bounds; meaningless for an empty frame, which never enters RUN
  always_ff @(posedge clk) begin
    if (start_ok) begin
      geom_last.width  <= cfg_width - 1'b1;
      geom_last.height <= cfg_height - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      stop_out  <= 1'b0;
      aborted   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            stop_out  <= 1'b0;
            aborted   <= 1'b0;
            stall_cnt <= '0;
            if (cfg_width == '0 || cfg_height == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              stop_out <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (s.valid && !m.ready) stall_cnt <= sat_inc(stall_cnt);
          // A final beat wins over a simultaneous abort: the frame is complete
          if ((xfer && pos_eof) || abort) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            stop_out <= 1'b1;
            aborted  <= !(xfer && pos_eof);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Directed-plus-random bench for stream_frame_ctrl with a frame-level model
// of beat order, line/frame tags, completion and stall accounting.
module tb_stream_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] cfg_width, cfg_height;
  logic        m_eol, m_eof, busy, done, stop_out, aborted;
  logic [31:0] stall_cnt;
  int          checks = 0;
  int          errors = 0;

  stream_frame_ctrl_if #(.DATA_W(8)) s_if ();
  stream_frame_ctrl_if #(.DATA_W(8)) m_if ();

  stream_frame_ctrl #(.DATA_W(8), .DIM_W(16), .STAT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .s          (s_if),
    .m          (m_if),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .busy       (busy),
    .done       (done),
    .stop_out   (stop_out),
    .aborted    (aborted),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame. abort_at>0 aborts together with that (1-based) beat;
  // restart re-pulses start with other dimensions partway through.
  task automatic run_frame(input int w, input int h, input int v_pct, input int r_pct,
                           input int abort_at, input bit restart);
    logic [7:0] pix[$];
    int  total, idx, stalls, cyc;
    bit  exp_abort, stop_now;
    total = w * h;
    for (int i = 0; i < total; i++) pix.push_back(8'($urandom));
    idx = 0; stalls = 0; cyc = 0; exp_abort = 0; stop_now = (total == 0);
    @(negedge clk);
    cfg_width = 16'(w); cfg_height = 16'(h); start = 1'b1;
    s_if.valid = 1'b0; m_if.ready = 1'b0; abort = 1'b0;
    @(posedge clk);
    while (!stop_now) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      s_if.valid = ($urandom_range(99) < 32'(v_pct));
      m_if.ready = ($urandom_range(99) < 32'(r_pct));
      s_if.data  = pix[idx];
      if (abort_at > 0 && idx == abort_at - 1) begin
        s_if.valid = 1'b1; m_if.ready = 1'b1; abort = 1'b1;
      end
      if (restart && idx == 2) begin
        start = 1'b1; cfg_width = 16'd8; cfg_height = 16'd3;
      end
      #1;
      check("busy_run", 64'(busy), 64'(1));
      check("s_ready_run", 64'(s_if.ready), 64'(m_if.ready));
      check("m_valid_run", 64'(m_if.valid), 64'(s_if.valid));
      if (s_if.valid && m_if.ready) begin
        check("m_data", 64'(m_if.data), 64'(pix[idx]));
        check("m_eol", 64'(m_eol), 64'((idx % w) == w - 1));
        check("m_eof", 64'(m_eof), 64'(idx == total - 1));
        idx++;
        if (abort) exp_abort = (idx != total);
      end else if (s_if.valid) begin
        stalls++;
      end
      @(posedge clk);
      if (idx == total || abort) stop_now = 1'b1;
      cyc++;
      if (cyc > 5000) begin
        check("frame_timeout", 64'(1), 64'(0));
        stop_now = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; s_if.valid = 1'b1; m_if.ready = 1'b1;
    #1;
    check("beats_out", 64'(idx), 64'((abort_at > 0) ? abort_at : total));
    check("done_pulse", 64'(done), 64'(1));
    check("stop_out_set", 64'(stop_out), 64'(1));
    check("busy_done", 64'(busy), 64'(0));
    check("s_ready_done", 64'(s_if.ready), 64'(0));
    check("m_valid_done", 64'(m_if.valid), 64'(0));
    check("aborted", 64'(aborted), 64'(exp_abort));
    check("stall_cnt", 64'(stall_cnt), 64'(stalls));
    @(negedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("stop_out_hold", 64'(stop_out), 64'(1));
    check("s_ready_idle", 64'(s_if.ready), 64'(0));
    s_if.valid = 1'b0; m_if.ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_width = '0; cfg_height = '0;
    s_if.data = '0; s_if.valid = 1'b0; m_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; s_if.valid = 1'b1; m_if.ready = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_stop", 64'(stop_out), 64'(0));
    check("rst_aborted", 64'(aborted), 64'(0));
    check("rst_stall", 64'(stall_cnt), 64'(0));
    check("rst_s_ready", 64'(s_if.ready), 64'(0));
    check("rst_m_valid", 64'(m_if.valid), 64'(0));
    check("rst_eol_eof", 64'({m_eol, m_eof}), 64'(0));
    check("rst_col_row", 64'({dut.u_pos.col, dut.u_pos.row}), 64'(0));
    s_if.valid = 1'b0; m_if.ready = 1'b0;

    run_frame(4, 2, 100, 100, 0, 0);
    run_frame(4, 2, 100, 50, 0, 0);
    run_frame(4, 2, 70, 50, 0, 0);
    run_frame(5, 3, 80, 60, 0, 0);
    run_frame(0, 5, 100, 100, 0, 0);
    run_frame(256, 256, 100, 100, 1000, 0);
    run_frame(2, 2, 100, 100, 0, 0);
    run_frame(4, 2, 100, 100, 0, 1);
    run_frame(3, 2, 100, 100, 6, 0);

    // Reset in the middle of a 4x2 frame after three beats
    @(negedge clk);
    cfg_width = 16'd4; cfg_height = 16'd2; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; s_if.valid = 1'b1; m_if.ready = 1'b1; s_if.data = 8'(k);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1; s_if.valid = 1'b1; m_if.ready = 1'b0;
    @(posedge clk);
    #1;
    m_if.ready = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_stop", 64'(stop_out), 64'(0));
    check("mid_rst_s_ready", 64'(s_if.ready), 64'(0));
    check("mid_rst_col_row", 64'({dut.u_pos.col, dut.u_pos.row}), 64'(0));
    @(negedge clk);
    reset = 1'b0; s_if.valid = 1'b0; m_if.ready = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done), 64'(0));
    check("mid_rst_idle", 64'(busy), 64'(0));
    run_frame(4, 2, 100, 100, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_frame_ctrl.md
Name: stream_frame_ctrl

Overview:
- Frame-level sequencer between the blur accelerator's output stream and the downstream sink/writer.
- Accepts a start command with frame dimensions and gates the ready/valid stream to exactly width*height beats.
- Tags end-of-line and end-of-frame, then signals completion (done pulse, stop level).
- Also keeps a backpressure stall counter for performance debug.

Parameters:
- DATA_W, 8, pixel width in bits.
- DIM_W, 16, width of the frame dimension and position counters.
- STAT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command; sampled only in IDLE.
- abort  in  1  terminate the current frame early.
- cfg_width  in  DIM_W  pixels per line; latched on an accepted start.
- cfg_height  in  DIM_W  lines per frame; latched on an accepted start.
- s_data  in  DATA_W  upstream pixel.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- m_data  out  DATA_W  downstream pixel.
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- m_eol  out  1  qualifies the current m beat as the last pixel of a line.
- m_eof  out  1  qualifies the current m beat as the last pixel of the frame.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at frame end (normal end or abort).
- stop_out  out  1  level; high from DONE until the next accepted start.
- aborted  out  1  level; high if the last frame ended by abort.
- stall_cnt  out  STAT_W  RUN cycles with s_valid=1 and m_ready=0.

Behaviour:
- Reset values: FSM=IDLE; col=row=0; busy=done=stop_out=aborted=0; stall_cnt=0; m_valid=s_ready=m_eol=m_eof=0.
- States: IDLE, RUN, DONE.
- IDLE: s_ready=0, m_valid=0.
  - On start=1: latch cfg_width/cfg_height; clear col, row, stop_out, aborted, stall_cnt.
  - Next state is RUN, or DONE directly if either dimension is 0 (empty frame, no beats transferred).
- RUN: zero-latency combinational passthrough.
  - m_data=s_data, m_valid=s_valid, s_ready=m_ready.
  - A beat transfers when s_valid&m_ready.
  - m_eol = m_valid & (col==W-1).
  - m_eof = m_eol & (row==H-1).
- On each transfer:
  - col increments; at W-1 it wraps to 0 and row increments.
  - A transfer with m_eof=1 moves the FSM to DONE on the next edge. Counters are not advanced past the frame.
- Stalls: in RUN, stall_cnt increments each cycle with s_valid&~m_ready. It saturates at all-ones and does not wrap.
- abort in RUN: moves to DONE and sets aborted=1.
  - If a transfer completes in the same cycle as abort, that beat is passed downstream; no further beats are passed.
  - abort with the final (eof) beat: the frame counts as complete, aborted=0.
  - abort outside RUN is ignored.
- DONE lasts exactly one cycle:
  - done=1, stop_out set to 1, s_ready=m_valid=0.
  - Next state is IDLE.
  - start in DONE is ignored.
- start in RUN or DONE is ignored. Dimensions are never re-latched mid-frame.
- Outside RUN, upstream data is held off (s_ready=0), never dropped.
- Reset mid-frame:
  - Immediate return to the reset values listed above on the next edge.
  - No done pulse is generated.
  - The in-flight beat is not acknowledged unless m_ready&s_valid held in the reset cycle; downstream must also be reset.
- Widths: col/row are DIM_W bits. Comparisons use the latched W-1/H-1, computed at start (only valid when W, H ≥ 1).

Decomposition:
- Shared package stream_ctrl_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default DIM_W/STAT_W constants.
  - Frame-geometry struct {width, height}.
- One sub-module, frame_pos_counter:
  - col/row counters with enable, clear, wrap, and eol/eof flags.
  - Reusable by the input-side stream feeder.

Test Plan:
- W=4, H=2, start, s_valid and m_ready always 1 → 8 beats passed unchanged.
  - m_eol on beats 4 and 8; m_eof only on beat 8.
  - done pulse 1 cycle after beat 8; stop_out=1; busy drops.
- Same 4x2 frame with m_ready random 50% (stall 1-8 cycles) → all 8 data values arrive in order, no duplicates or drops.
  - stall_cnt equals the count of s_valid&~m_ready cycles in RUN.
- start with cfg_width=0, H=5 → s_ready stays 0, done pulse 1 cycle after start, stop_out=1, zero beats transferred.
- W=256, H=256, abort asserted after beat 1000 (with that beat transferring) → exactly 1000 beats out, no m_eof, done pulse, aborted=1.
  - A following start of 2x2 → clean 4-beat frame, aborted=0.
- start pulsed again during RUN with different dims (W=4,H=2 running, new W=8) → ignored; frame ends after 8 beats with the original eol positions.
- reset asserted mid-frame (after beat 3 of 4x2) → next cycle: IDLE, s_ready=0, col=row=0, stop_out=0, no done pulse.
  - A new 4x2 frame then completes normally.
